// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: store buffer default depth and the entry layout
// (word address plus store data).
package pipeline_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// Youngest-match selector: finds the most recently enqueued valid entry whose
// word address matches the load address.
module sb_fwd_select
  import pipeline_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PW-1:0]         tail_i,
  input  logic [29:0]           addr_i,
  output logic                  hit_o,
  output logic [31:0]           data_o
);

  logic [PW-1:0] idx;

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); the last
  // match seen wins, so the youngest matching store is forwarded.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PW'(k);
      if (valid_i[idx] && (entries_i[idx].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: queues stores, drains
// them in program order, and forwards buffered data to matching loads.
module store_buffer
  import pipeline_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic                     memread,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     stall,
  output logic                     fwd_hit,
  output logic                     mem_valid,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  output logic [31:0]              rd_addr,
  input  logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] buf_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic full, empty, enq, deq;
  logic sel_hit;
  logic [31:0] sel_data;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^dataadr[1:0];

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign enq   = memwrite & ~full;
  assign deq   = ~empty & mem_ready;

  // Outputs are forced quiet while reset is asserted so the pipeline never
  // sees a stale drain, stall or forward during the flush cycle.
  assign stall     = memwrite & full & ~reset;
  assign mem_valid = ~empty & ~reset;
  assign mem_addr  = {buf_q[head_q].addr, 2'b00};
  assign mem_wdata = buf_q[head_q].data;
  assign count     = count_q;
  assign rd_addr   = dataadr;

  sb_fwd_select #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries_i (buf_q),
    .valid_i   (valid_q),
    .tail_i    (tail_q),
    .addr_i    (dataadr[31:2]),
    .hit_o     (sel_hit),
    .data_o    (sel_data)
  );

  assign fwd_hit  = memread & sel_hit & ~reset;
  assign readdata = fwd_hit ? sel_data : rd_data;

  // Enqueue and dequeue never touch the same slot: enqueue is blocked when
  // full, and dequeue is blocked when empty.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_q[tail_q] <= '{addr: dataadr[31:2], data: writedata};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic, checked
// cycle by cycle against a queue-based model of the buffer.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, memwrite, memread, mem_ready;
  logic [31:0] dataadr, writedata, rd_data;
  logic [31:0] readdata, mem_addr, mem_wdata, rd_addr;
  logic        stall, fwd_hit, mem_valid;
  logic [$clog2(DEPTH):0] count;

  logic [61:0] q[$];
  logic [61:0] iss[$];
  logic [61:0] drn[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .fwd_hit   (fwd_hit),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic re,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] rdd);
    reset     = rst;
    memwrite  = we;
    memread   = re;
    dataadr   = adr;
    writedata = wd;
    mem_ready = rdy;
    rd_data   = rdd;
  endtask

  // Check all outputs against the model mid-cycle, then advance the model by
  // one clock using the buffer's architectural rules.
  task automatic step();
    logic [31:0] e_rd;
    logic        e_fwd;
    logic        was_full;
    @(negedge clk);
    e_fwd = 1'b0;
    e_rd  = rd_data;
    if (!reset && memread)
      for (int i = 0; i < q.size(); i++)
        if (q[i][61:32] == dataadr[31:2]) begin
          e_fwd = 1'b1;
          e_rd  = q[i][31:0];
        end
    was_full = (q.size() == DEPTH);
    chk("count", 64'(count), 64'(q.size()));
    chk("mem_valid", 64'(mem_valid), 64'(!reset && q.size() > 0));
    if (!reset && q.size() > 0) begin
      chk("mem_addr", 64'(mem_addr), 64'({q[0][61:32], 2'b00}));
      chk("mem_wdata", 64'(mem_wdata), 64'(q[0][31:0]));
    end
    chk("stall", 64'(stall), 64'(!reset && memwrite && was_full));
    chk("fwd_hit", 64'(fwd_hit), 64'(e_fwd));
    chk("readdata", 64'(readdata), 64'(e_rd));
    chk("rd_addr", 64'(rd_addr), 64'(dataadr));
    if (mem_valid && mem_ready && !reset) drn.push_back({mem_addr[31:2], mem_wdata});
    if (reset) begin
      q.delete();
      iss.delete();
      drn.delete();
    end else begin
      if (q.size() > 0 && mem_ready) void'(q.pop_front());
      if (memwrite && !was_full) begin
        q.push_back({dataadr[31:2], writedata});
        iss.push_back({dataadr[31:2], writedata});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int issued;
    int guard;
    logic rdy;
    logic acc;

    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 32'd17);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_mem_valid", 64'(mem_valid), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);

    // Single store held while memory is not ready
    drive(0, 1, 0, 32'd84, 32'd7654, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("hold_count", 64'(count), 64'd1);
      chk("hold_valid", 64'(mem_valid), 64'd1);
      chk("hold_addr", 64'(mem_addr), 64'd84);
      chk("hold_wdata", 64'(mem_wdata), 64'd7654);
      step();
    end

    // In-order drain of two stores
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 32'd40, 32'd36, 1, 0);
    step();
    drive(0, 1, 0, 32'd60, 32'd36, 1, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      step();
    end
    chk("drain_n", 64'(drn.size()), 64'd2);
    if (drn.size() == 2) begin
      chk("drain_first", 64'({drn[0][61:32], 2'b00}), 64'd40);
      chk("drain_second", 64'({drn[1][61:32], 2'b00}), 64'd60);
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(mem_valid), 64'd0);

    // Forwarding: youngest match wins, low address bits ignored
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 32'd80, 32'd5, 0, 0);
    step();
    drive(0, 1, 0, 32'd80, 32'd9, 0, 0);
    step();
    drive(0, 0, 1, 32'd82, 0, 0, 32'd999);
    #1;
    chk("fwd_young_data", 64'(readdata), 64'd9);
    chk("fwd_young_hit", 64'(fwd_hit), 64'd1);
    step();
    drive(0, 0, 1, 32'd88, 0, 0, 32'd123);
    #1;
    chk("fwd_miss_data", 64'(readdata), 64'd123);
    chk("fwd_miss_hit", 64'(fwd_hit), 64'd0);
    step();

    // Full buffer stalls; a drain in the same cycle does not bypass
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 32'(16 * i), 32'(100 + i), 0, 0);
      step();
    end
    drive(0, 1, 0, 32'd200, 32'd777, 0, 0);
    #1;
    chk("full_stall", 64'(stall), 64'd1);
    chk("full_count", 64'(count), 64'(DEPTH));
    step();
    drive(0, 1, 0, 32'd200, 32'd777, 1, 0);
    #1;
    chk("full_drain_stall", 64'(stall), 64'd1);
    step();
    drive(0, 1, 0, 32'd200, 32'd777, 0, 0);
    #1;
    chk("after_drain_stall", 64'(stall), 64'd0);
    step();
    chk("after_drain_count", 64'(count), 64'(DEPTH));

    // Pointer wrap with ready toggling every cycle
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    issued = 0;
    guard  = 0;
    rdy    = 1'b0;
    while (issued < 3 * DEPTH && guard < 200) begin
      rdy = ~rdy;
      drive(0, 1, 0, 32'($urandom_range(0, 7)) * 4, $urandom, rdy, 0);
      acc = (q.size() < DEPTH);
      step();
      if (acc) issued++;
      guard++;
    end
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      step();
      guard++;
    end
    chk("wrap_issued", 64'(issued), 64'(3 * DEPTH));
    chk("wrap_count", 64'(count), 64'd0);
    chk("wrap_drained", 64'(drn.size()), 64'(3 * DEPTH));
    for (int i = 0; i < drn.size() && i < iss.size(); i++)
      chk("wrap_order", 64'(drn[i]), 64'(iss[i]));

    // Reset while draining discards buffered stores
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 32'd100, 32'd11, 0, 0);
    step();
    drive(0, 1, 0, 32'd104, 32'd22, 0, 0);
    step();
    drive(1, 0, 1, 32'd100, 0, 0, 32'd55);
    #1;
    chk("rst_mid_valid", 64'(mem_valid), 64'd0);
    chk("rst_mid_fwd", 64'(fwd_hit), 64'd0);
    step();
    drive(0, 0, 1, 32'd100, 0, 0, 32'd55);
    #1;
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_valid", 64'(mem_valid), 64'd0);
    chk("post_rst_fwd", 64'(fwd_hit), 64'd0);
    chk("post_rst_data", 64'(readdata), 64'd55);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("post_rst_idle", 64'(mem_valid), 64'd0);

    // Randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
            32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)),
            $urandom, 1'($urandom), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
